// File: rtl/counter_updown_pmod_pkg.sv
// Shared types and elaboration helpers for the up/down modulo counter.
// Direction encoding and prescaler width sizing live here so every file agrees.
package counter_updown_pmod_pkg;

   typedef enum logic {
      DIR_DOWN = 1'b0,
      DIR_UP   = 1'b1
   } dir_e;

   // A prescaler of N phases needs clog2(N) bits, but never fewer than one.
   function automatic int ps_width(input int prescale);
      int w;
      w = $clog2(prescale);
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/counter_updown_pmod_if.sv
// Control/status bundle of the up/down counter.
// The master drives strobes, load and compare values; the slave returns count and flags.
interface counter_updown_pmod_if #(
   parameter int WIDTH = 12
);

   logic             load;
   logic             enable;
   logic             up_dn;
   logic [WIDTH-1:0] b;
   logic [WIDTH-1:0] cmp_val;
   logic [WIDTH-1:0] c;
   logic             tc;
   logic             match;

   modport master (
      output load,
      output enable,
      output up_dn,
      output b,
      output cmp_val,
      input  c,
      input  tc,
      input  match
   );

   modport slave (
      input  load,
      input  enable,
      input  up_dn,
      input  b,
      input  cmp_val,
      output c,
      output tc,
      output match
   );

endinterface

// File: rtl/counter_updown_pmod_tick_prescaler.sv
// Enable-gated prescaler: issues one step every PRESCALE enabled cycles.
// The phase holds while enable is low and is cleared by clr (the counter's load).
module counter_updown_pmod_tick_prescaler
   import counter_updown_pmod_pkg::*;
#(
   parameter int PRESCALE = 1
) (
   input  logic clk,
   input  logic reset,
   input  logic clr,
   input  logic enable,
   output logic step
);

   localparam int PS_W = ps_width(PRESCALE);

   generate
      if (PRESCALE <= 1) begin : g_bypass
         // No phase to track: every enabled cycle is a step.
         logic unused_ok;
         assign unused_ok = &{1'b0, clk, reset, clr};
         assign step      = enable;
      end else begin : g_count
         localparam logic [PS_W-1:0] LAST = PS_W'(PRESCALE - 1);

         logic [PS_W-1:0] cnt_q;
         logic [PS_W-1:0] cnt_d;

         always_comb begin
            cnt_d = cnt_q;
            if (clr) begin
               cnt_d = '0;
            end else if (enable) begin
               cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
            end
         end

         always_ff @(posedge clk) begin
            if (reset) begin
               cnt_q <= '0;
            end else begin
               cnt_q <= cnt_d;
            end
         end

         assign step = enable & (cnt_q == LAST);
      end
   endgenerate

endmodule

// File: rtl/counter_updown_pmod.sv
// Parametrised up/down modulo counter with wrap/saturate, prescaler,
// registered terminal-count pulse and combinational compare-match.
module counter_updown_pmod
   import counter_updown_pmod_pkg::*;
#(
   parameter int WIDTH    = 12,
   parameter int MAX_VAL  = 4095,
   parameter bit SATURATE = 1'b0,
   parameter int PRESCALE = 1
) (
   input logic                  clk,
   input logic                  reset,
   counter_updown_pmod_if.slave bus
);

   localparam logic [WIDTH-1:0] MAX_C = WIDTH'(MAX_VAL);

   logic [WIDTH-1:0] c_q;
   logic [WIDTH-1:0] c_d;
   logic             tc_q;
   logic             tc_d;
   logic             ps_step;
   logic             step;
   logic             at_bound;
   dir_e             dir;

   assign dir = dir_e'(bus.up_dn);

   counter_updown_pmod_tick_prescaler #(
      .PRESCALE (PRESCALE)
   ) u_prescaler (
      .clk    (clk),
      .reset  (reset),
      .clr    (bus.load),
      .enable (bus.enable),
      .step   (ps_step)
   );

   // A load cycle never steps, even if the prescaler phase is due.
   assign step     = ps_step & ~bus.load;
   assign at_bound = (dir == DIR_UP) ? (c_q == MAX_C) : (c_q == '0);

   function automatic logic [WIDTH-1:0] clamp_load(input logic [WIDTH-1:0] val);
      return (val > MAX_C) ? MAX_C : val;
   endfunction

   function automatic logic [WIDTH-1:0] bound_next(input logic [WIDTH-1:0] cur,
                                                   input dir_e             d);
      if (SATURATE) begin
         return cur;
      end
      return (d == DIR_UP) ? '0 : MAX_C;
   endfunction

   always_comb begin
      c_d  = c_q;
      tc_d = 1'b0;
      if (bus.load) begin
         c_d = clamp_load(bus.b);
      end else if (step) begin
         tc_d = at_bound;
         if (at_bound) begin
            c_d = bound_next(c_q, dir);
         end else if (dir == DIR_UP) begin
            c_d = c_q + 1'b1;
         end else begin
            c_d = c_q - 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         c_q  <= '0;
         tc_q <= 1'b0;
      end else begin
         c_q  <= c_d;
         tc_q <= tc_d;
      end
   end

   assign bus.c     = c_q;
   assign bus.tc    = tc_q;
   assign bus.match = (c_q == bus.cmp_val);

endmodule

// File: tb/tb_counter_updown_pmod.sv
// Bench for counter_updown_pmod: four configurations driven side by side,
// each compared every cycle against an arithmetic reference model.
module tb_counter_updown_pmod;

   localparam int N = 4;
   // Instance configurations: wrap-9, saturate-9, prescale-4 full range, max-1000.
   int P_MAX [N] = '{9, 9, 4095, 1000};
   bit P_SAT [N] = '{1'b0, 1'b1, 1'b0, 1'b0};
   int P_PS  [N] = '{1, 1, 4, 1};

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic        ld [N];
   logic        en [N];
   logic        ud [N];
   logic [11:0] bv [N];
   logic [11:0] cv [N];
   logic [11:0] cobs [N];
   logic        tobs [N];
   logic        mobs [N];

   int mc [N];
   int mps [N];
   bit mtc [N];

   int nchk  = 0;
   int npass = 0;

   counter_updown_pmod_if #(.WIDTH(12)) if0 ();
   counter_updown_pmod_if #(.WIDTH(12)) if1 ();
   counter_updown_pmod_if #(.WIDTH(12)) if2 ();
   counter_updown_pmod_if #(.WIDTH(12)) if3 ();

   assign if0.load = ld[0]; assign if0.enable = en[0]; assign if0.up_dn = ud[0];
   assign if0.b = bv[0];    assign if0.cmp_val = cv[0];
   assign if1.load = ld[1]; assign if1.enable = en[1]; assign if1.up_dn = ud[1];
   assign if1.b = bv[1];    assign if1.cmp_val = cv[1];
   assign if2.load = ld[2]; assign if2.enable = en[2]; assign if2.up_dn = ud[2];
   assign if2.b = bv[2];    assign if2.cmp_val = cv[2];
   assign if3.load = ld[3]; assign if3.enable = en[3]; assign if3.up_dn = ud[3];
   assign if3.b = bv[3];    assign if3.cmp_val = cv[3];

   assign cobs[0] = if0.c; assign tobs[0] = if0.tc; assign mobs[0] = if0.match;
   assign cobs[1] = if1.c; assign tobs[1] = if1.tc; assign mobs[1] = if1.match;
   assign cobs[2] = if2.c; assign tobs[2] = if2.tc; assign mobs[2] = if2.match;
   assign cobs[3] = if3.c; assign tobs[3] = if3.tc; assign mobs[3] = if3.match;

   counter_updown_pmod #(.WIDTH(12), .MAX_VAL(9), .SATURATE(1'b0), .PRESCALE(1))
      u_wrap (.clk(clk), .reset(rst), .bus(if0.slave));
   counter_updown_pmod #(.WIDTH(12), .MAX_VAL(9), .SATURATE(1'b1), .PRESCALE(1))
      u_sat (.clk(clk), .reset(rst), .bus(if1.slave));
   counter_updown_pmod #(.WIDTH(12), .MAX_VAL(4095), .SATURATE(1'b0), .PRESCALE(4))
      u_ps4 (.clk(clk), .reset(rst), .bus(if2.slave));
   counter_updown_pmod #(.WIDTH(12), .MAX_VAL(1000), .SATURATE(1'b0), .PRESCALE(1))
      u_max1k (.clk(clk), .reset(rst), .bus(if3.slave));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nchk++;
      assert (obs === exp) npass++;
      else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
   endtask

   // Reference model: the count as a number on the ring 0..MAX (or clamped interval).
   task automatic model_edge();
      bit step;
      for (int i = 0; i < N; i++) begin
         if (rst === 1'b1) begin
            mc[i] = 0; mps[i] = 0; mtc[i] = 1'b0;
         end else if (ld[i] === 1'b1) begin
            mc[i]  = (int'(bv[i]) > P_MAX[i]) ? P_MAX[i] : int'(bv[i]);
            mps[i] = 0; mtc[i] = 1'b0;
         end else begin
            step   = (en[i] === 1'b1) && (mps[i] == P_PS[i] - 1);
            if (en[i] === 1'b1) mps[i] = step ? 0 : mps[i] + 1;
            mtc[i] = 1'b0;
            if (step && ud[i] === 1'b1) begin
               mtc[i] = (mc[i] == P_MAX[i]);
               mc[i]  = P_SAT[i] ? ((mc[i] + 1 > P_MAX[i]) ? P_MAX[i] : mc[i] + 1)
                                 : (mc[i] + 1) % (P_MAX[i] + 1);
            end else if (step) begin
               mtc[i] = (mc[i] == 0);
               mc[i]  = P_SAT[i] ? ((mc[i] == 0) ? 0 : mc[i] - 1)
                                 : (mc[i] + P_MAX[i]) % (P_MAX[i] + 1);
            end
         end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge();
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
         chk($sformatf("c[%0d]", i), 32'(cobs[i]), 32'(mc[i]));
         chk($sformatf("tc[%0d]", i), 32'(tobs[i]), 32'(mtc[i]));
         chk($sformatf("match[%0d]", i), 32'(mobs[i]), 32'(mc[i] == int'(cv[i])));
      end
   endtask

   task automatic set_all(input logic l, input logic e, input logic u, input logic [11:0] b);
      for (int i = 0; i < N; i++) begin
         ld[i] = l; en[i] = e; ud[i] = u; bv[i] = b;
      end
   endtask

   int enp  [6] = '{1, 1, 0, 0, 1, 1};
   int exp4 [6] = '{1, 1, 1, 1, 1, 2};

   initial begin
      for (int i = 0; i < N; i++) cv[i] = 12'd5;
      // Reset beats a simultaneous load
      rst = 1'b1;
      set_all(1'b1, 1'b0, 1'b1, 12'h123);
      tick();
      chk("rst_c", 32'(cobs[0]), 32'd0);
      chk("rst_tc", 32'(tobs[0]), 32'd0);
      rst = 1'b0;

      // Wrap up through 9 back to 0, then down from 0
      set_all(1'b0, 1'b1, 1'b1, 12'd0);
      for (int k = 1; k <= 10; k++) begin
         tick();
         chk("wrap_up_c", 32'(cobs[0]), 32'(k % 10));
         chk("wrap_up_tc", 32'(tobs[0]), 32'(k == 10));
      end
      set_all(1'b0, 1'b1, 1'b0, 12'd0);
      tick();
      chk("wrap_dn_c", 32'(cobs[0]), 32'd9);
      chk("wrap_dn_tc", 32'(tobs[0]), 32'd1);

      // Saturate at the top and bottom
      set_all(1'b1, 1'b0, 1'b1, 12'd8);
      tick();
      set_all(1'b0, 1'b1, 1'b1, 12'd0);
      for (int k = 0; k < 3; k++) begin
         tick();
         chk("sat_up_c", 32'(cobs[1]), 32'd9);
         chk("sat_up_tc", 32'(tobs[1]), 32'(k != 0));
      end
      set_all(1'b1, 1'b0, 1'b1, 12'd0);
      tick();
      set_all(1'b0, 1'b1, 1'b0, 12'd0);
      tick();
      chk("sat_dn_c", 32'(cobs[1]), 32'd0);
      chk("sat_dn_tc", 32'(tobs[1]), 32'd1);

      // Prescale 4, stretched by an enable gap, phase cleared by load
      set_all(1'b1, 1'b0, 1'b1, 12'd0);
      tick();
      set_all(1'b0, 1'b1, 1'b1, 12'd0);
      for (int k = 1; k <= 4; k++) begin
         tick();
         chk("ps_first", 32'(cobs[2]), 32'(k == 4));
      end
      for (int k = 0; k < 6; k++) begin
         set_all(1'b0, 1'(enp[k]), 1'b1, 12'd0);
         tick();
         chk("ps_gap", 32'(cobs[2]), 32'(exp4[k]));
      end
      tick();
      tick();
      set_all(1'b1, 1'b1, 1'b1, 12'd7);
      tick();
      chk("ps_load", 32'(cobs[2]), 32'd7);
      set_all(1'b0, 1'b1, 1'b1, 12'd0);
      for (int k = 1; k <= 4; k++) begin
         tick();
         chk("ps_clr", 32'(cobs[2]), (k == 4) ? 32'd8 : 32'd7);
      end

      // Load clamps to MAX_VAL; load with enable takes b without stepping
      set_all(1'b1, 1'b0, 1'b1, 12'hFFF);
      tick();
      chk("clamp_1k", 32'(cobs[3]), 32'd1000);
      chk("clamp_9", 32'(cobs[0]), 32'd9);
      set_all(1'b1, 1'b1, 1'b1, 12'h100);
      tick();
      chk("load_en", 32'(cobs[3]), 32'h100);
      set_all(1'b0, 1'b0, 1'b1, 12'd0);
      tick();
      chk("hold", 32'(cobs[3]), 32'h100);

      // Compare match at 5, then reverse direction
      set_all(1'b1, 1'b0, 1'b1, 12'd0);
      tick();
      set_all(1'b0, 1'b1, 1'b1, 12'd0);
      for (int k = 1; k <= 5; k++) begin
         tick();
         chk("match5", 32'(mobs[0]), 32'(k == 5));
      end
      set_all(1'b0, 1'b1, 1'b0, 12'd0);
      tick();
      chk("rev_c", 32'(cobs[0]), 32'd4);
      chk("rev_match", 32'(mobs[0]), 32'd0);

      // Reset mid-count with load and step both due
      rst = 1'b1;
      set_all(1'b1, 1'b1, 1'b1, 12'h123);
      tick();
      chk("rst_mid", 32'(cobs[2]), 32'd0);
      rst = 1'b0;

      // Random traffic against the model
      for (int n = 0; n < 400; n++) begin
         rst = ($urandom_range(63) == 0);
         for (int i = 0; i < N; i++) begin
            ld[i] = ($urandom_range(7) == 0);
            en[i] = ($urandom_range(3) != 0);
            ud[i] = 1'($urandom_range(1));
            bv[i] = ($urandom_range(1) == 0) ? 12'($urandom_range(4095)) : 12'($urandom_range(12));
            cv[i] = 12'($urandom_range(12));
         end
         tick();
      end

      $display("%0d/%0d checks passed", npass, nchk);
      $finish;
   end

endmodule
